// File: rtl/keypad_debounce_decoder_if.sv
// Keypad decoder bus: scanner row/column inputs plus decoded key and digit history.
interface keypad_debounce_decoder_if;
  logic [3:0] r_sel;
  logic [3:0] c_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  modport master (
    output r_sel, c_in,
    input  key_code, key_valid, key_held, digit_new, digit_old
  );

  modport slave (
    input  r_sel, c_in,
    output key_code, key_valid, key_held, digit_new, digit_old
  );
endinterface

// File: rtl/keypad_debounce_decoder.sv
// Synchronizes keypad columns, debounces a single key against the scanned row,
// decodes it to hex and keeps a two-digit history for the display stage.
module keypad_debounce_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  keypad_debounce_decoder_if.slave   kp
);
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       row_cap_reg;
  logic [1:0]       col_cap_reg;
  logic [3:0]       c_meta_reg, c_s_reg;
  logic [3:0]       r_dly_reg, r_d_reg;
  logic [3:0]       key_code_reg, digit_new_reg, digit_old_reg;
  logic             key_valid_reg, key_held_reg;

  logic [3:0]       row_hit, col_hit;
  logic [1:0]       row_idx, col_idx;
  logic             row_ok, col_ok, qual, cap_col_high;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       decoded;

  function automatic logic [3:0] decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // One-cold pattern detectors for the delayed row and synchronized columns.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hit
    assign row_hit[gi] = (r_d_reg == ~(4'(1) << gi));
    assign col_hit[gi] = (c_s_reg == ~(4'(1) << gi));
  end

  assign row_ok       = |row_hit;
  assign col_ok       = |col_hit;
  assign row_idx      = {row_hit[3] | row_hit[2], row_hit[3] | row_hit[1]};
  assign col_idx      = {col_hit[3] | col_hit[2], col_hit[3] | col_hit[1]};
  assign qual         = (r_d_reg == ~(4'(1) << row_cap_reg));
  assign cap_col_high = c_s_reg[col_cap_reg];
  assign cnt_inc      = (cnt_reg < DEB_CNT) ? cnt_reg + CNT_W'(1) : cnt_reg;
  assign decoded      = decode(row_cap_reg, col_cap_reg);

  // Row is delayed by the same two stages as the columns so samples stay paired.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_meta_reg <= 4'b1111;
      c_s_reg    <= 4'b1111;
      r_dly_reg  <= 4'b1111;
      r_d_reg    <= 4'b1111;
    end else begin
      c_meta_reg <= kp.c_in;
      c_s_reg    <= c_meta_reg;
      r_dly_reg  <= kp.r_sel;
      r_d_reg    <= r_dly_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      row_cap_reg   <= 2'd0;
      col_cap_reg   <= 2'd0;
      key_code_reg  <= 4'd0;
      digit_new_reg <= 4'd0;
      digit_old_reg <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (row_ok && col_ok) begin
            row_cap_reg <= row_idx;
            col_cap_reg <= col_idx;
            cnt_reg     <= CNT_W'(1);
            state_reg   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (qual) begin
            if (!cap_col_high) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc >= DEB_CNT) begin
                state_reg     <= HELD;
                key_valid_reg <= 1'b1;
                key_held_reg  <= 1'b1;
                key_code_reg  <= decoded;
                digit_new_reg <= decoded;
                digit_old_reg <= digit_new_reg;
              end
            end else begin
              cnt_reg   <= '0;
              state_reg <= IDLE;
            end
          end
        end
        HELD: begin
          if (qual && cap_col_high) begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          if (qual) begin
            if (cap_col_high) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc >= DEB_CNT) begin
                cnt_reg      <= '0;
                key_held_reg <= 1'b0;
                state_reg    <= IDLE;
              end
            end else begin
              cnt_reg   <= '0;
              state_reg <= HELD;
            end
          end
        end
        default: begin
          cnt_reg      <= '0;
          key_held_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = key_held_reg;
  assign kp.digit_new = digit_new_reg;
  assign kp.digit_old = digit_old_reg;
endmodule

// File: tb/tb_keypad_debounce_decoder.sv
// Directed and randomized key presses checked against cycle counts derived from
// the debounce rules and a bench-side digit history.
module tb_keypad_debounce_decoder;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  keypad_debounce_decoder_if kp_if();

  keypad_debounce_decoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [3:0] exp_new = 4'd0;
  logic [3:0] exp_old = 4'd0;
  logic [3:0] exp_code = 4'd0;
  int key_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  function automatic logic [3:0] one_cold(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare the pulse/held flags seen after the rising edge.
  task automatic cyc(input string tag, input bit ev, input bit eh);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(kp_if.key_valid), 32'(ev));
    chk({tag, ".held"},  32'(kp_if.key_held),  32'(eh));
    if (kp_if.key_valid === 1'b1) pulses++;
  endtask

  task automatic chk_digits(input string tag);
    chk({tag, ".code"}, 32'(kp_if.key_code),  32'(exp_code));
    chk({tag, ".new"},  32'(kp_if.digit_new), 32'(exp_new));
    chk({tag, ".old"},  32'(kp_if.digit_old), 32'(exp_old));
  endtask

  // Press with the scanner on the key's row; acceptance lands 2 sync cycles plus
  // DEB qualifying samples after the stable press starts.
  task automatic press_key(input string tag, input int row, input int col, input int hold,
                           input bit pre_b, input bit scan, input bit rel_b);
    int off;
    int acc;
    int drop;
    off  = pre_b ? 3 : 0;
    acc  = off + DEB + 2;
    drop = rel_b ? DEB + 5 : DEB + 2;
    for (int i = 0; i < off + hold; i++) begin
      int sr;
      sr = row;
      if (scan && i >= acc + 2 && i < off + hold - 4) sr = i % 4;
      kp_if.r_sel = one_cold(sr);
      if (sr != row)             kp_if.c_in = 4'($urandom_range(0, 15));
      else if (pre_b && i == 2)  kp_if.c_in = 4'hF;
      else                       kp_if.c_in = one_cold(col);
      cyc(tag, (i + 1) == acc, (i + 1) >= acc);
      if ((i + 1) == acc) begin
        exp_old  = exp_new;
        exp_new  = 4'(key_tab[row * 4 + col]);
        exp_code = exp_new;
        exp_pulses++;
        chk_digits({tag, ".accept"});
      end
    end
    kp_if.r_sel = one_cold(row);
    for (int j = 0; j < drop + 3; j++) begin
      kp_if.c_in = (rel_b && j == 2) ? one_cold(col) : 4'hF;
      cyc({tag, ".rel"}, 1'b0, (j + 1) < drop);
    end
    chk_digits({tag, ".after"});
    $display("press %s row=%0d col=%0d hold=%0d bounce=%0d scan=%0d relbounce=%0d code=%h",
             tag, row, col, hold, pre_b, scan, rel_b, exp_new);
  endtask

  initial begin
    kp_if.r_sel = 4'b1110;
    kp_if.c_in  = 4'b0000;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_digits("reset");
    chk("reset.valid", 32'(kp_if.key_valid), 32'd0);
    chk("reset.held",  32'(kp_if.key_held),  32'd0);
    $display("reset held 3 cycles, outputs code=%h new=%h old=%h", kp_if.key_code, kp_if.digit_new, kp_if.digit_old);
    reset = 1'b1;
    kp_if.c_in = 4'hF;
    repeat (3) cyc("idle", 1'b0, 1'b0);

    press_key("key6", 1, 2, 10, 1'b0, 1'b0, 1'b0);
    press_key("key1", 0, 0, 12, 1'b0, 1'b0, 1'b0);
    press_key("key0", 3, 1, 12, 1'b0, 1'b0, 1'b0);
    chk("two_presses.pulses", 32'(pulses), 32'(exp_pulses));
    press_key("bounce9", 2, 2, 12, 1'b1, 1'b0, 1'b0);
    press_key("holdA", 0, 3, 50, 1'b0, 1'b1, 1'b1);
    chk("hold.pulses", 32'(pulses), 32'(exp_pulses));

    // Two or more columns low on one row must never be captured.
    kp_if.r_sel = one_cold(2);
    for (int t = 0; t < 4; t++) begin
      logic [3:0] m;
      m = 4'($urandom_range(0, 15));
      while ($countones(~m) < 2) m = 4'($urandom_range(0, 15));
      kp_if.c_in = m;
      repeat (4) cyc("multikey", 1'b0, 1'b0);
      $display("multikey c_in=%b no capture", m);
    end
    kp_if.c_in = 4'hF;
    repeat (3) cyc("multikey.idle", 1'b0, 1'b0);
    chk_digits("multikey");

    // Reset while debouncing discards the press and clears the history.
    kp_if.r_sel = one_cold(1);
    kp_if.c_in  = one_cold(0);
    repeat (4) cyc("rst_deb", 1'b0, 1'b0);
    reset = 1'b0;
    kp_if.c_in = 4'hF;
    repeat (2) cyc("rst_deb.rst", 1'b0, 1'b0);
    exp_new = 4'd0; exp_old = 4'd0; exp_code = 4'd0;
    chk_digits("rst_deb");
    reset = 1'b1;
    repeat (10) cyc("rst_deb.idle", 1'b0, 1'b0);
    $display("reset during debounce, no pulse");
    press_key("post_rst_key5", 1, 1, 10, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int gap;
      press_key("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(10, 30),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      gap = $urandom_range(1, 4);
      for (int g = 0; g < gap; g++) begin
        kp_if.r_sel = one_cold($urandom_range(0, 3));
        cyc("rand.gap", 1'b0, 1'b0);
      end
    end
    chk("total.pulses", 32'(pulses), 32'(exp_pulses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_debounce_decoder.md
Name: keypad_debounce_decoder

Overview:
- Sits directly downstream of the keypad row-scan FSM.
- Takes the active-low row drive `r_sel` from that FSM and the active-low keypad column lines.
- Synchronizes and debounces a single key press, decodes it to a 4-bit hex code, and emits one `key_valid` pulse per press.
- Keeps a two-digit history (newest/older) that feeds the dual seven-segment display stage.

Parameters:
- DEBOUNCE_CYCLES, 4, number of qualifying stable samples needed to accept a press or a release (legal range 2..255).
- CNT_W, 8, width of the debounce counter (must satisfy 2^CNT_W > DEBOUNCE_CYCLES).

Ports:
- clk  input  1  scan clock, same clock that drives the row-scan FSM
- reset  input  1  synchronous, active-low
- r_sel  input  4  row drive from the scanner, active-low one-cold (1110=row0 … 0111=row3)
- c_in  input  4  raw keypad columns, asynchronous, pulled up, active-low (bit0=col0)
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_held  output  1  high from acceptance until the debounced release completes
- digit_new  output  4  most recent accepted key
- digit_old  output  4  key accepted before `digit_new`

Behaviour:
- **Reset:** applies on the `clk` edge while `reset=0`.
  - State goes to IDLE.
  - Counter, captured row/column, `key_code`, `digit_new`, `digit_old` = 0.
  - `key_valid` and `key_held` = 0.
  - Synchronizer flops = 4'b1111; `r_sel` delay flops = 4'b1111.
  - Reset mid-press discards the press; no `key_valid` is emitted.
- **Synchronizer:** `c_in` passes through a 2-flop synchronizer giving `c_s`.
  - `r_sel` is delayed by 2 flops giving `r_d`, so row and column samples stay aligned.
  - All decisions below use `r_d` and `c_s`.
- **Qualifying sample:** any cycle in which `r_d` equals the captured row. Cycles in which a different row is driven are ignored, and the counter holds.
- **Key map (row, col0..3):**
  - row0 = 1, 2, 3, A
  - row1 = 4, 5, 6, B
  - row2 = 7, 8, 9, C
  - row3 = E, 0, F, D
- **IDLE:**
  - If `r_d` is one-cold and `c_s` has exactly one bit low: capture row and column, set counter = 1, go to DEBOUNCE.
  - If zero or two or more column bits are low: stay in IDLE. Multi-key presses are rejected.
- **DEBOUNCE:** on a qualifying sample:
  - If the captured column is low: counter +1. When the counter reaches DEBOUNCE_CYCLES, go to HELD.
  - If the captured column is high (bounce): go to IDLE, counter = 0.
- **Entry to HELD (registered, next cycle):**
  - `key_valid` = 1 for exactly one cycle.
  - `key_code` = decoded key.
  - `digit_old` <= `digit_new`; `digit_new` <= decoded key.
  - `key_held` = 1.
- **HELD:**
  - On a qualifying sample with the captured column high: counter = 1, go to RELEASE.
  - Other keys pressed on other rows or columns are ignored.
- **RELEASE:** on a qualifying sample:
  - Column high: counter +1. When the counter reaches DEBOUNCE_CYCLES, go to IDLE, `key_held` = 0, counter = 0.
  - Column low: return to HELD, counter = 0, no new `key_valid`.
- **Latency:**
  - A clean press produces `key_valid` 2 (sync) + N cycles after the first capture sample, where N is the number of cycles until the DEBOUNCE_CYCLES-th qualifying sample.
  - With the scanner frozen on the pressed row, N = DEBOUNCE_CYCLES.
- **Invariants:**
  - `key_code` and the digits are stable except on the `key_valid` cycle.
  - Exactly one `key_valid` per accepted press, regardless of hold length.
- **Counter:** saturates at DEBOUNCE_CYCLES and never wraps.
- **Illegal states:** any illegal encoding returns to IDLE.

Test Plan:
- Reset held low for 3 cycles with `c_in`=0000 → all outputs 0, no `key_valid`.
- `r_sel` frozen 1101, `c_in` col2 low (1011), stable 10 cycles → a single `key_valid` 2+4 cycles after the first sample, `key_code`=6, `digit_new`=6, `digit_old`=0, `key_held`=1.
- Press 1 then 0 with full release between → `digit_old`=1, `digit_new`=0, two `key_valid` pulses total.
- Bounce: captured column low 2 qualifying samples, high 1, then stable low → no pulse from the bounce; `key_valid` only after 4 consecutive low qualifying samples.
- Hold key 'A' (row0/col3) for 50 cycles, with release bouncing low once at release count 2 → exactly one `key_valid`; `key_held` drops only after 4 consecutive high samples.
- Two columns low on the same row from IDLE → no capture and no `key_valid`. Assert reset during DEBOUNCE → IDLE, no pulse.
